ten_eth_lookup_arb: RTL and testbench



---
 rtl/ten_eth_pkg.sv | 32 +++
 rtl/ten_eth_lookup_arb_rr_arbiter.sv | 51 +++++
 rtl/ten_eth_lookup_arb.sv | 183 ++++++++++++++++++
 tb/tb_ten_eth_lookup_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ten_eth_pkg.sv
// Shared widths, FSM encoding and pending-entry payload for the 10G lookup arbiter.
package ten_eth_pkg;

  localparam int unsigned MAC_W     = 48;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned OUTPORT_W = 4;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned TIMER_W   = 16;

  localparam logic [OUTPORT_W-1:0] MISS_PORT_DFLT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic             vld;
    logic [MAC_W-1:0] mac;
    logic [ID_W-1:0]  id;
  } pend_t;

  // Saturating add of a small increment onto a statistics counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/ten_eth_lookup_arb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at rr_ptr,
// pointer advances past the winner when the grant is taken.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt_c,
  output logic [$clog2(N)-1:0] gnt_idx_c,
  output logic                 any_c
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] cand;
  int unsigned      sum;

  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    any_c     = 1'b0;
    cand      = '0;
    sum       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = 32'(rr_ptr_q) + i;
      if (sum >= N) sum = sum - N;
      cand = IDX_W'(sum);
      if (!any_c && req[cand]) begin
        any_c         = 1'b1;
        gnt_idx_c     = cand;
        gnt_c[cand]   = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (en && any_c) begin
      rr_ptr_d = (gnt_idx_c == IDX_W'(N-1)) ? '0 : gnt_idx_c + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/ten_eth_lookup_arb.sv
// Shares one outport-lookup engine between P_PORT_NUM RX ports: per-port
// pending slots, round-robin grant, one lookup in flight, timeout watchdog.
module ten_eth_lookup_arb
  import ten_eth_pkg::*;
#(
  parameter int unsigned          P_PORT_NUM  = 2,
  parameter int unsigned          P_TIMEOUT   = 255,
  parameter logic [OUTPORT_W-1:0] P_MISS_PORT = MISS_PORT_DFLT
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [P_PORT_NUM-1:0]       i_check_valid,
  input  logic [MAC_W*P_PORT_NUM-1:0] i_check_mac,
  input  logic [ID_W*P_PORT_NUM-1:0]  i_check_id,
  output logic                        m_lookup_valid,
  output logic [MAC_W-1:0]            m_lookup_mac,
  output logic [ID_W-1:0]             m_lookup_id,
  input  logic                        s_lookup_ready,
  input  logic                        s_result_valid,
  input  logic [OUTPORT_W-1:0]        s_result_outport,
  input  logic                        s_result_seek_flag,
  output logic [P_PORT_NUM-1:0]       o_result_valid,
  output logic [OUTPORT_W-1:0]        o_outport,
  output logic [ID_W-1:0]             o_check_id,
  output logic                        o_seek_flag,
  output logic [CNT_W-1:0]            o_drop_cnt,
  output logic [CNT_W-1:0]            o_timeout_cnt
);

  localparam int unsigned IDX_W = $clog2(P_PORT_NUM);

  pend_t                 pend_q [P_PORT_NUM];
  pend_t                 pend_d [P_PORT_NUM];
  logic [P_PORT_NUM-1:0] pend_vld_c;
  logic [3:0]            drop_num_c;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cur_idx_q, cur_idx_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;

  logic                  m_lookup_valid_q, m_lookup_valid_d;
  logic [MAC_W-1:0]      m_lookup_mac_q, m_lookup_mac_d;
  logic [ID_W-1:0]       m_lookup_id_q, m_lookup_id_d;
  logic [P_PORT_NUM-1:0] o_result_valid_q, o_result_valid_d;
  logic [OUTPORT_W-1:0]  o_outport_q, o_outport_d;
  logic [ID_W-1:0]       o_check_id_q, o_check_id_d;
  logic                  o_seek_flag_q, o_seek_flag_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]      timeout_cnt_q, timeout_cnt_d;

  logic [P_PORT_NUM-1:0] arb_gnt_c;
  logic [IDX_W-1:0]      arb_idx_c;
  logic                  arb_any_c;
  logic                  arb_en_c;

  rr_arbiter #(.N(P_PORT_NUM)) u_arb (
    .clk       (i_clk),
    .rst       (i_rst),
    .req       (pend_vld_c),
    .en        (arb_en_c),
    .gnt_c     (arb_gnt_c),
    .gnt_idx_c (arb_idx_c),
    .any_c     (arb_any_c)
  );

  // Pending slots: a new request beats a same-cycle grant clear; a request
  // hitting an occupied, ungranted slot is dropped and counted.
  always_comb begin
    drop_num_c = '0;
    pend_vld_c = '0;
    for (int p = 0; p < P_PORT_NUM; p++) begin
      pend_vld_c[p] = pend_q[p].vld;
      pend_d[p]     = pend_q[p];
      if (i_check_valid[p] && (!pend_q[p].vld || (arb_en_c && arb_gnt_c[p]))) begin
        pend_d[p] = '{vld: 1'b1,
                      mac: i_check_mac[p*MAC_W +: MAC_W],
                      id:  i_check_id[p*ID_W +: ID_W]};
      end else if (arb_en_c && arb_gnt_c[p]) begin
        pend_d[p].vld = 1'b0;
      end else if (i_check_valid[p]) begin
        drop_num_c = drop_num_c + 4'd1;
      end
    end
    drop_cnt_d = sat_add(drop_cnt_q, drop_num_c);
  end

  always_comb begin
    state_d          = state_q;
    cur_idx_d        = cur_idx_q;
    timer_d          = timer_q;
    m_lookup_valid_d = m_lookup_valid_q;
    m_lookup_mac_d   = m_lookup_mac_q;
    m_lookup_id_d    = m_lookup_id_q;
    o_result_valid_d = '0;
    o_outport_d      = o_outport_q;
    o_check_id_d     = o_check_id_q;
    o_seek_flag_d    = o_seek_flag_q;
    timeout_cnt_d    = timeout_cnt_q;
    arb_en_c         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any_c) begin
          arb_en_c         = 1'b1;
          cur_idx_d        = arb_idx_c;
          m_lookup_valid_d = 1'b1;
          m_lookup_mac_d   = pend_q[arb_idx_c].mac;
          m_lookup_id_d    = pend_q[arb_idx_c].id;
          state_d          = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (s_lookup_ready) begin
          m_lookup_valid_d = 1'b0;
          timer_d          = '0;
          state_d          = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        // A result landing on the expiry cycle still counts as a real result.
        if (s_result_valid) begin
          o_result_valid_d = P_PORT_NUM'(1) << cur_idx_q;
          o_outport_d      = s_result_outport;
          o_seek_flag_d    = s_result_seek_flag;
          o_check_id_d     = m_lookup_id_q;
          state_d          = ST_IDLE;
        end else if (timer_q == TIMER_W'(P_TIMEOUT - 1)) begin
          o_result_valid_d = P_PORT_NUM'(1) << cur_idx_q;
          o_outport_d      = P_MISS_PORT;
          o_seek_flag_d    = 1'b0;
          o_check_id_d     = m_lookup_id_q;
          timeout_cnt_d    = sat_add(timeout_cnt_q, 4'd1);
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int p = 0; p < P_PORT_NUM; p++) pend_q[p] <= '0;
      state_q          <= ST_IDLE;
      cur_idx_q        <= '0;
      timer_q          <= '0;
      m_lookup_valid_q <= 1'b0;
      m_lookup_mac_q   <= '0;
      m_lookup_id_q    <= '0;
      o_result_valid_q <= '0;
      o_outport_q      <= '0;
      o_check_id_q     <= '0;
      o_seek_flag_q    <= 1'b0;
      drop_cnt_q       <= '0;
      timeout_cnt_q    <= '0;
    end else begin
      for (int p = 0; p < P_PORT_NUM; p++) pend_q[p] <= pend_d[p];
      state_q          <= state_d;
      cur_idx_q        <= cur_idx_d;
      timer_q          <= timer_d;
      m_lookup_valid_q <= m_lookup_valid_d;
      m_lookup_mac_q   <= m_lookup_mac_d;
      m_lookup_id_q    <= m_lookup_id_d;
      o_result_valid_q <= o_result_valid_d;
      o_outport_q      <= o_outport_d;
      o_check_id_q     <= o_check_id_d;
      o_seek_flag_q    <= o_seek_flag_d;
      drop_cnt_q       <= drop_cnt_d;
      timeout_cnt_q    <= timeout_cnt_d;
    end
  end

  assign m_lookup_valid = m_lookup_valid_q;
  assign m_lookup_mac   = m_lookup_mac_q;
  assign m_lookup_id    = m_lookup_id_q;
  assign o_result_valid = o_result_valid_q;
  assign o_outport      = o_outport_q;
  assign o_check_id     = o_check_id_q;
  assign o_seek_flag    = o_seek_flag_q;
  assign o_drop_cnt     = drop_cnt_q;
  assign o_timeout_cnt  = timeout_cnt_q;

endmodule

// File: tb/tb_ten_eth_lookup_arb.sv
// Bench for ten_eth_lookup_arb: behavioural lookup engine, result scoreboard,
// table of single transactions plus hand-written multi-cycle sequences.
module tb_ten_eth_lookup_arb;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_check_valid;
  logic [95:0] i_check_mac;
  logic [7:0]  i_check_id;
  logic        m_lookup_valid;
  logic [47:0] m_lookup_mac;
  logic [3:0]  m_lookup_id;
  logic        s_lookup_ready;
  logic        s_result_valid;
  logic [3:0]  s_result_outport;
  logic        s_result_seek_flag;
  logic [1:0]  o_result_valid;
  logic [3:0]  o_outport;
  logic [3:0]  o_check_id;
  logic        o_seek_flag;
  logic [15:0] o_drop_cnt;
  logic [15:0] o_timeout_cnt;

  ten_eth_lookup_arb #(.P_PORT_NUM(2), .P_TIMEOUT(8), .P_MISS_PORT(4'hF)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_check_valid(i_check_valid), .i_check_mac(i_check_mac), .i_check_id(i_check_id),
    .m_lookup_valid(m_lookup_valid), .m_lookup_mac(m_lookup_mac), .m_lookup_id(m_lookup_id),
    .s_lookup_ready(s_lookup_ready), .s_result_valid(s_result_valid),
    .s_result_outport(s_result_outport), .s_result_seek_flag(s_result_seek_flag),
    .o_result_valid(o_result_valid), .o_outport(o_outport), .o_check_id(o_check_id),
    .o_seek_flag(o_seek_flag), .o_drop_cnt(o_drop_cnt), .o_timeout_cnt(o_timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] vld;
    logic [3:0] outp;
    logic [3:0] id;
    logic       seek;
  } exp_t;

  typedef struct {
    int          port;
    logic [47:0] mac;
    logic [3:0]  id;
    int          delay;
    logic [3:0]  exp_out;
    logic        exp_seek;
    int          to_inc;
  } row_t;

  int   n_tests = 0;
  int   n_fail = 0;
  int   results_seen = 0;
  exp_t sb_q[$];

  // Engine model: result arrives eng_delay WAIT cycles after handshake (0 = never);
  // outport = mac[3:0], seek = ~mac[5].
  int          eng_delay = 1;
  int          cd = 0;
  logic        hs_pend = 1'b0;
  logic [47:0] hs_mac = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (m_lookup_valid && s_lookup_ready) begin
      hs_pend = 1'b1;
      hs_mac  = m_lookup_mac;
    end
  end

  initial begin
    s_result_valid = 1'b0;
    s_result_outport = '0;
    s_result_seek_flag = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s_result_valid = 1'b0;
      if (hs_pend) begin
        hs_pend = 1'b0;
        cd = eng_delay;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          s_result_valid     = 1'b1;
          s_result_outport   = hs_mac[3:0];
          s_result_seek_flag = ~hs_mac[5];
        end
      end
    end
  end

  // Scoreboard: every result pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (o_result_valid !== 2'b00) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got valid=%b expected no pulse", o_result_valid);
      end else begin
        e = sb_q.pop_front();
        chk("res_port", 64'(o_result_valid), 64'(e.vld));
        chk("res_outport", 64'(o_outport), 64'(e.outp));
        chk("res_id", 64'(o_check_id), 64'(e.id));
        chk("res_seek", 64'(o_seek_flag), 64'(e.seek));
      end
      results_seen++;
    end
  end

  task automatic push_exp(input int port, input logic [3:0] outp, input logic [3:0] id,
                          input logic seek);
    exp_t e;
    e.vld  = 2'b01 << port;
    e.outp = outp;
    e.id   = id;
    e.seek = seek;
    sb_q.push_back(e);
  endtask

  task automatic req(input int p, input logic [47:0] mac, input logic [3:0] id);
    i_check_valid[p]       = 1'b1;
    i_check_mac[p*48 +: 48] = mac;
    i_check_id[p*4 +: 4]    = id;
    step();
    i_check_valid = '0;
  endtask

  task automatic wait_results(input int target, input string name);
    int n = 0;
    while (results_seen < target && n < 60) begin
      step();
      n++;
    end
    chk(name, 64'(results_seen), 64'(target));
  endtask

  task automatic do_reset(input int cycles);
    i_rst = 1'b1;
    repeat (cycles) step();
    i_rst = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_m_valid", 64'(m_lookup_valid), 64'(0));
    chk("rst_m_mac", 64'(m_lookup_mac), 64'(0));
    chk("rst_m_id", 64'(m_lookup_id), 64'(0));
    chk("rst_res_valid", 64'(o_result_valid), 64'(0));
    chk("rst_outport", 64'(o_outport), 64'(0));
    chk("rst_check_id", 64'(o_check_id), 64'(0));
    chk("rst_seek", 64'(o_seek_flag), 64'(0));
    chk("rst_drop_cnt", 64'(o_drop_cnt), 64'(0));
    chk("rst_timeout_cnt", 64'(o_timeout_cnt), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[7];
    int   exp_to;
    int   tgt;

    rows[0] = '{1, 48'h8DBC5C4A0002, 4'h1, 1, 4'h2, 1'b1, 0};
    rows[1] = '{0, 48'h001122334455, 4'h3, 3, 4'h5, 1'b1, 0};
    rows[2] = '{1, 48'hFFFFFFFFFF13, 4'hF, 8, 4'h3, 1'b1, 0};  // result on expiry cycle
    rows[3] = '{0, 48'h000000000000, 4'h0, 0, 4'hF, 1'b0, 1};  // no result
    rows[4] = '{1, 48'hA5A5A5A5A5A5, 4'h9, 9, 4'hF, 1'b0, 1};  // late result ignored
    rows[5] = '{0, 48'h0123456789AB, 4'h6, 2, 4'hB, 1'b0, 0};
    rows[6] = '{0, 48'h00000000001E, 4'hC, 7, 4'hE, 1'b1, 0};

    i_check_valid  = '0;
    i_check_mac    = '0;
    i_check_id     = '0;
    s_lookup_ready = 1'b1;
    do_reset(3);
    chk_reset_vals();
    step();

    // Single request with exact latency: request cycle 0, pulse in cycle 4.
    eng_delay = 1;
    push_exp(1, 4'h2, 4'h1, 1'b1);
    tgt = results_seen + 1;
    req(1, 48'h8DBC5C4A0002, 4'h1);
    chk("lat_no_early_pulse", 64'(o_result_valid), 64'(0));
    step(); step(); step();
    chk("lat_valid", 64'(o_result_valid), 64'(2'b10));
    chk("lat_outport", 64'(o_outport), 64'(4'h2));
    chk("lat_id", 64'(o_check_id), 64'(4'h1));
    chk("lat_seek", 64'(o_seek_flag), 64'(1));
    step();
    chk("lat_pulse_single", 64'(o_result_valid), 64'(0));
    chk("lat_outport_hold", 64'(o_outport), 64'(4'h2));
    wait_results(tgt, "lat_done");

    exp_to = 0;
    for (int i = 0; i < 7; i++) begin
      eng_delay = rows[i].delay;
      exp_to += rows[i].to_inc;
      push_exp(rows[i].port, rows[i].exp_out, rows[i].id, rows[i].exp_seek);
      tgt = results_seen + 1;
      req(rows[i].port, rows[i].mac, rows[i].id);
      wait_results(tgt, "row_done");
      repeat (4) step();
      chk("row_timeout_cnt", 64'(o_timeout_cnt), 64'(exp_to));
      chk("row_outport_hold", 64'(o_outport), 64'(rows[i].exp_out));
    end

    // Fairness from reset: both request together twice, port 0 first each time.
    do_reset(1);
    eng_delay = 1;
    for (int rnd = 0; rnd < 2; rnd++) begin
      push_exp(0, 4'h3, 4'h4, 1'b1);
      push_exp(1, 4'h7, 4'h5, 1'b0);
      tgt = results_seen + 2;
      i_check_valid = 2'b11;
      i_check_mac   = {48'h000000000027, 48'h000000000003};
      i_check_id    = {4'h5, 4'h4};
      step();
      i_check_valid = '0;
      wait_results(tgt, "fair_done");
      repeat (2) step();
    end

    // Backpressure: request held stable while ready is low.
    s_lookup_ready = 1'b0;
    push_exp(0, 4'h8, 4'h2, 1'b1);
    tgt = results_seen + 1;
    req(0, 48'h123456789A48, 4'h2);
    step();
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 64'(m_lookup_valid), 64'(1));
      chk("bp_mac", 64'(m_lookup_mac), 64'(48'h123456789A48));
      chk("bp_id", 64'(m_lookup_id), 64'(4'h2));
      step();
    end
    s_lookup_ready = 1'b1;
    step();
    chk("bp_handshake", 64'(m_lookup_valid), 64'(0));
    wait_results(tgt, "bp_done");
    repeat (2) step();

    // Drop: second port-0 request while the first waits behind port 1.
    eng_delay = 6;
    push_exp(1, 4'h1, 4'h7, 1'b0);
    push_exp(0, 4'h4, 4'h8, 1'b1);
    tgt = results_seen + 2;
    req(1, 48'h000000000061, 4'h7);
    req(0, 48'h000000000004, 4'h8);
    req(0, 48'h000000000009, 4'h9);
    chk("drop_cnt", 64'(o_drop_cnt), 64'(1));
    wait_results(tgt, "drop_done");
    repeat (2) step();
    chk("drop_cnt_hold", 64'(o_drop_cnt), 64'(1));

    // Reset while a lookup is outstanding in WAIT: no pulse, clean restart.
    eng_delay = 0;
    req(1, 48'h000000000002, 4'h3);
    repeat (3) step();
    chk("rw_in_wait", 64'(m_lookup_valid), 64'(0));
    do_reset(1);
    chk_reset_vals();
    repeat (12) step();
    chk("rw_no_timeout", 64'(o_timeout_cnt), 64'(0));
    eng_delay = 2;
    push_exp(0, 4'hC, 4'hA, 1'b1);
    tgt = results_seen + 1;
    req(0, 48'h00000000000C, 4'hA);
    wait_results(tgt, "rw_done");
    repeat (2) step();
    chk("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
